// File: rtl/halfbridge_duty_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// halfbridge_duty_ctrl : soft-start / shutdown duty sequencer for halfbridge.
// Rev 1.0
// ---------------------------------------------------------------------------
module halfbridge_duty_ctrl #(
   parameter int DW       = 10,
   parameter int STEP     = 4,
   parameter int MAX_DUTY = 1000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   input  logic          period_tick,
   input  logic          en,
   input  logic          fault,
   input  logic          fault_clr,
   input  logic          cmd_valid,
   input  logic [DW-1:0] cmd_duty,
   output logic          cmd_ready,
   output logic [DW-1:0] d_halfbridge,
   output logic [2:0]    state,
   output logic          at_target,
   output logic          fault_latched
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HOLD  = 3'd1,
      RAMP  = 3'd2,
      SHDN  = 3'd3,
      FAULT = 3'd4
   } state_t;

   localparam logic [DW:0] STEP_X = (DW+1)'(STEP);
   localparam logic [DW:0] MAX_X  = (DW+1)'(MAX_DUTY);

   state_t        state_q, state_d;
   logic [DW-1:0] duty_q, duty_d;
   logic [DW-1:0] tgt_q, tgt_d;
   logic          at_q;

   logic          tk;
   logic [DW:0]   duty_x, tgt_x, diff;
   logic [DW-1:0] stepped;
   logic          step_done;
   logic [DW-1:0] cmd_clamped;

   assign tk = period_tick & ce;

   // One step toward target, computed one bit wider so neither direction wraps.
   always_comb begin
      duty_x    = {1'b0, duty_q};
      tgt_x     = {1'b0, tgt_q};
      diff      = (tgt_x >= duty_x) ? (tgt_x - duty_x) : (duty_x - tgt_x);
      step_done = (diff <= STEP_X);
      if (step_done)
         stepped = tgt_q;
      else if (tgt_x > duty_x)
         stepped = DW'(duty_x + STEP_X);
      else
         stepped = DW'(duty_x - STEP_X);
   end

   assign cmd_clamped = ({1'b0, cmd_duty} > MAX_X) ? DW'(MAX_X) : cmd_duty;

   always_comb begin
      state_d   = state_q;
      duty_d    = duty_q;
      tgt_d     = tgt_q;
      cmd_ready = 1'b0;
      if (fault) begin
         state_d = FAULT;
         duty_d  = '0;
         tgt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               duty_d = '0;
               tgt_d  = '0;
               if (en)
                  state_d = HOLD;
            end
            HOLD: begin
               if (!en) begin
                  tgt_d   = '0;
                  state_d = SHDN;
               end else begin
                  cmd_ready = 1'b1;
                  if (cmd_valid) begin
                     tgt_d = cmd_clamped;
                     if (cmd_clamped != duty_q)
                        state_d = RAMP;
                  end
               end
            end
            RAMP: begin
               if (!en) begin
                  tgt_d   = '0;
                  state_d = SHDN;
               end else if (tk) begin
                  duty_d = stepped;
                  if (step_done)
                     state_d = HOLD;
               end
            end
            // Target is already zero here; en returning does not abort the ramp-down.
            SHDN: begin
               if (duty_q == '0) begin
                  state_d = IDLE;
               end else if (tk) begin
                  duty_d = stepped;
                  if (step_done)
                     state_d = IDLE;
               end
            end
            FAULT: begin
               duty_d = '0;
               tgt_d  = '0;
               if (fault_clr && !en)
                  state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               duty_d  = '0;
               tgt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         duty_q  <= '0;
         tgt_q   <= '0;
         at_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         tgt_q   <= tgt_d;
         at_q    <= (duty_d == tgt_d);
      end
   end

   assign d_halfbridge  = duty_q;
   assign state         = state_q;
   assign at_target     = at_q;
   assign fault_latched = (state_q == FAULT);

endmodule
`default_nettype wire

// File: tb/tb_halfbridge_duty_ctrl.sv
`default_nettype none
// tb_halfbridge_duty_ctrl : directed and randomized checks against a closed-form ramp model.
module tb_halfbridge_duty_ctrl;
   localparam int DW = 10, STEP = 4, MAX_DUTY = 1000;
   localparam int S_IDLE = 0, S_HOLD = 1, S_RAMP = 2, S_SHDN = 3, S_FAULT = 4;

   logic          clk = 1'b0, rst = 1'b0, ce = 1'b1, period_tick = 1'b0;
   logic          en = 1'b0, fault = 1'b0, fault_clr = 1'b0, cmd_valid = 1'b0;
   logic [DW-1:0] cmd_duty = '0;
   logic          cmd_ready, at_target, fault_latched;
   logic [DW-1:0] d_halfbridge;
   logic [2:0]    state;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   halfbridge_duty_ctrl #(.DW(DW), .STEP(STEP), .MAX_DUTY(MAX_DUTY)) dut (
      .clk(clk), .rst(rst), .ce(ce), .period_tick(period_tick), .en(en),
      .fault(fault), .fault_clr(fault_clr), .cmd_valid(cmd_valid),
      .cmd_duty(cmd_duty), .cmd_ready(cmd_ready), .d_halfbridge(d_halfbridge),
      .state(state), .at_target(at_target), .fault_latched(fault_latched)
   );

   // Duty after k effective ticks of a ramp from a toward b.
   function automatic int exp_duty(input int a, input int b, input int k);
      int d;
      d = (b > a) ? b - a : a - b;
      if (k * STEP >= d) return b;
      return (b > a) ? a + k * STEP : a - k * STEP;
   endfunction

   task automatic cyc(input bit t);
      period_tick = t;
      @(posedge clk);
      #1;
      period_tick = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; fault = 1'b0; fault_clr = 1'b0; cmd_valid = 1'b0; ce = 1'b1;
      cyc(0);
      rst = 1'b0;
   endtask

   task automatic enter_hold();
      en = 1'b1;
      cyc(0);
   endtask

   task automatic command(input int v, input bit t);
      cmd_valid = 1'b1;
      cmd_duty  = DW'(v);
      cyc(t);
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; cmd_valid = 1'b1; cmd_duty = 10'd50;
      cyc(1);
      rst = 1'b0; en = 1'b0; cmd_valid = 1'b0;
      vectors++; if (d_halfbridge !== 10'd0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", d_halfbridge); end
      vectors++; if (state !== 3'(S_IDLE)) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
      vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
      vectors++; if (at_target !== 1'b1) begin errors++; $display("FAIL reset_at_target: got %b expected 1", at_target); end
      vectors++; if (fault_latched !== 1'b0) begin errors++; $display("FAIL reset_fault_latched: got %b expected 0", fault_latched); end
   endtask

   task automatic test_ramp_up();
      do_reset();
      enter_hold();
      vectors++; if (state !== 3'(S_HOLD)) begin errors++; $display("FAIL ramp_up_hold: got %0d expected %0d", state, S_HOLD); end
      vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ramp_up_ready: got %b expected 1", cmd_ready); end
      command(100, 1'b1);
      vectors++; if (d_halfbridge !== 10'd0) begin errors++; $display("FAIL ramp_up_accept_duty: got %0d expected 0", d_halfbridge); end
      vectors++; if (state !== 3'(S_RAMP)) begin errors++; $display("FAIL ramp_up_accept_state: got %0d expected %0d", state, S_RAMP); end
      vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ramp_up_accept_ready: got %b expected 0", cmd_ready); end
      vectors++; if (at_target !== 1'b0) begin errors++; $display("FAIL ramp_up_accept_at: got %b expected 0", at_target); end
      for (int k = 1; k <= 25; k++) begin
         repeat ($urandom_range(0, 2)) cyc(0);
         cyc(1);
         vectors++; if (int'(d_halfbridge) != exp_duty(0, 100, k)) begin errors++; $display("FAIL ramp_up_duty k=%0d: got %0d expected %0d", k, d_halfbridge, exp_duty(0, 100, k)); end
         vectors++; if (int'(state) != ((k < 25) ? S_RAMP : S_HOLD)) begin errors++; $display("FAIL ramp_up_state k=%0d: got %0d", k, state); end
         vectors++; if (at_target !== (k == 25)) begin errors++; $display("FAIL ramp_up_at k=%0d: got %b expected %b", k, at_target, (k == 25)); end
      end
   endtask

   task automatic test_clamp();
      do_reset();
      enter_hold();
      command(1023, 1'b0);
      for (int k = 1; k <= 250; k++) begin
         cyc(1);
         vectors++; if (int'(d_halfbridge) != exp_duty(0, MAX_DUTY, k)) begin errors++; $display("FAIL clamp_duty k=%0d: got %0d expected %0d", k, d_halfbridge, exp_duty(0, MAX_DUTY, k)); end
         vectors++; if (int'(d_halfbridge) > MAX_DUTY) begin errors++; $display("FAIL clamp_limit k=%0d: got %0d expected <= %0d", k, d_halfbridge, MAX_DUTY); end
      end
      vectors++; if (state !== 3'(S_HOLD)) begin errors++; $display("FAIL clamp_state: got %0d expected %0d", state, S_HOLD); end
      cyc(1);
      vectors++; if (d_halfbridge !== 10'd1000) begin errors++; $display("FAIL clamp_settle: got %0d expected 1000", d_halfbridge); end
   endtask

   task automatic test_partial();
      do_reset();
      enter_hold();
      command(100, 1'b0);
      repeat (25) cyc(1);
      vectors++; if (d_halfbridge !== 10'd100) begin errors++; $display("FAIL partial_start: got %0d expected 100", d_halfbridge); end
      vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL partial_ready_hold: got %b expected 1", cmd_ready); end
      command(10, 1'b0);
      vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL partial_ready_ramp: got %b expected 0", cmd_ready); end
      for (int k = 1; k <= 23; k++) begin
         cyc(1);
         vectors++; if (int'(d_halfbridge) != exp_duty(100, 10, k)) begin errors++; $display("FAIL partial_duty k=%0d: got %0d expected %0d", k, d_halfbridge, exp_duty(100, 10, k)); end
         vectors++; if (cmd_ready !== (k == 23)) begin errors++; $display("FAIL partial_ready k=%0d: got %b expected %b", k, cmd_ready, (k == 23)); end
      end
   endtask

   task automatic test_fault();
      do_reset();
      enter_hold();
      command(100, 1'b0);
      repeat (12) cyc(1);
      vectors++; if (d_halfbridge !== 10'd48) begin errors++; $display("FAIL fault_pre_duty: got %0d expected 48", d_halfbridge); end
      fault = 1'b1;
      cyc(1);
      vectors++; if (d_halfbridge !== 10'd0) begin errors++; $display("FAIL fault_duty: got %0d expected 0", d_halfbridge); end
      vectors++; if (state !== 3'(S_FAULT)) begin errors++; $display("FAIL fault_state: got %0d expected %0d", state, S_FAULT); end
      vectors++; if (fault_latched !== 1'b1) begin errors++; $display("FAIL fault_latched: got %b expected 1", fault_latched); end
      vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fault_ready: got %b expected 0", cmd_ready); end
      fault = 1'b0; fault_clr = 1'b1;
      cyc(1);
      vectors++; if (state !== 3'(S_FAULT)) begin errors++; $display("FAIL fault_clr_en_high: got %0d expected %0d", state, S_FAULT); end
      vectors++; if (d_halfbridge !== 10'd0) begin errors++; $display("FAIL fault_hold_duty: got %0d expected 0", d_halfbridge); end
      en = 1'b0; fault = 1'b1;
      cyc(0);
      vectors++; if (state !== 3'(S_FAULT)) begin errors++; $display("FAIL fault_clr_fault_high: got %0d expected %0d", state, S_FAULT); end
      fault = 1'b0;
      cyc(0);
      fault_clr = 1'b0;
      vectors++; if (state !== 3'(S_IDLE)) begin errors++; $display("FAIL fault_exit_state: got %0d expected %0d", state, S_IDLE); end
      vectors++; if (fault_latched !== 1'b0) begin errors++; $display("FAIL fault_exit_latched: got %b expected 0", fault_latched); end
   endtask

   task automatic test_disable();
      do_reset();
      enter_hold();
      command(40, 1'b0);
      repeat (10) cyc(1);
      vectors++; if (d_halfbridge !== 10'd40) begin errors++; $display("FAIL disable_pre_duty: got %0d expected 40", d_halfbridge); end
      en = 1'b0; cmd_valid = 1'b1; cmd_duty = 10'd200;
      cyc(1);
      vectors++; if (state !== 3'(S_SHDN)) begin errors++; $display("FAIL disable_state: got %0d expected %0d", state, S_SHDN); end
      vectors++; if (d_halfbridge !== 10'd40) begin errors++; $display("FAIL disable_entry_duty: got %0d expected 40", d_halfbridge); end
      for (int k = 1; k <= 10; k++) begin
         if (k == 5) en = 1'b1;
         vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL disable_ready k=%0d: got %b expected 0", k, cmd_ready); end
         cyc(1);
         vectors++; if (int'(d_halfbridge) != exp_duty(40, 0, k)) begin errors++; $display("FAIL disable_duty k=%0d: got %0d expected %0d", k, d_halfbridge, exp_duty(40, 0, k)); end
         vectors++; if (int'(state) != ((k < 10) ? S_SHDN : S_IDLE)) begin errors++; $display("FAIL disable_state k=%0d: got %0d", k, state); end
      end
      cmd_valid = 1'b0;
      cyc(0);
      vectors++; if (state !== 3'(S_HOLD)) begin errors++; $display("FAIL disable_rearm: got %0d expected %0d", state, S_HOLD); end
      vectors++; if (d_halfbridge !== 10'd0) begin errors++; $display("FAIL disable_rearm_duty: got %0d expected 0", d_halfbridge); end
   endtask

   task automatic test_ce_rst();
      do_reset();
      enter_hold();
      command(200, 1'b0);
      repeat (5) cyc(1);
      ce = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc(1);
         vectors++; if (d_halfbridge !== 10'd20) begin errors++; $display("FAIL ce_frozen k=%0d: got %0d expected 20", k, d_halfbridge); end
         vectors++; if (state !== 3'(S_RAMP)) begin errors++; $display("FAIL ce_state k=%0d: got %0d expected %0d", k, state, S_RAMP); end
      end
      ce = 1'b1;
      cyc(1);
      vectors++; if (d_halfbridge !== 10'd24) begin errors++; $display("FAIL ce_resume: got %0d expected 24", d_halfbridge); end
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      vectors++; if (d_halfbridge !== 10'd0) begin errors++; $display("FAIL rst_mid_duty: got %0d expected 0", d_halfbridge); end
      vectors++; if (state !== 3'(S_IDLE)) begin errors++; $display("FAIL rst_mid_state: got %0d expected %0d", state, S_IDLE); end
      vectors++; if (at_target !== 1'b1) begin errors++; $display("FAIL rst_mid_at: got %b expected 1", at_target); end
      vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b expected 0", cmd_ready); end
      vectors++; if (fault_latched !== 1'b0) begin errors++; $display("FAIL rst_mid_latched: got %b expected 0", fault_latched); end
   endtask

   task automatic test_random();
      int a, b, raw, n, k, guard;
      bit t;
      do_reset();
      enter_hold();
      a = 0;
      repeat (20) begin
         raw = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 1023));
         b = (raw > MAX_DUTY) ? MAX_DUTY : raw;
         command(raw, 1'($urandom_range(0, 1)));
         vectors++; if (int'(state) != ((b != a) ? S_RAMP : S_HOLD)) begin errors++; $display("FAIL rand_accept_state %0d->%0d: got %0d", a, b, state); end
         vectors++; if (int'(d_halfbridge) != a) begin errors++; $display("FAIL rand_accept_duty: got %0d expected %0d", d_halfbridge, a); end
         n = (((b > a) ? b - a : a - b) + STEP - 1) / STEP;
         k = 0;
         guard = 0;
         while (k < n && guard < 5000) begin
            t  = 1'($urandom_range(0, 1));
            ce = ($urandom_range(0, 3) != 0);
            cyc(t);
            if (t && ce) k++;
            guard++;
            vectors++; if (int'(d_halfbridge) != exp_duty(a, b, k)) begin errors++; $display("FAIL rand_duty %0d->%0d k=%0d: got %0d expected %0d", a, b, k, d_halfbridge, exp_duty(a, b, k)); end
         end
         ce = 1'b1;
         vectors++; if (guard >= 5000) begin errors++; $display("FAIL rand_timeout: got %0d ticks expected %0d", k, n); end
         vectors++; if (state !== 3'(S_HOLD)) begin errors++; $display("FAIL rand_end_state: got %0d expected %0d", state, S_HOLD); end
         vectors++; if (at_target !== 1'b1) begin errors++; $display("FAIL rand_end_at: got %b expected 1", at_target); end
         a = b;
      end
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_ramp_up();
      test_clamp();
      test_partial();
      test_fault();
      test_disable();
      test_ce_rst();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
